// File: rtl/mem_stage_64x8_if.sv
// Request/response bundle for the 64x8 clear-on-reset memory stage.
// The requester drives the master side; the memory stage implements the slave side.
interface mem_stage_64x8_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              en;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              ready;
  logic [7:0]        wr_cnt;
  logic [7:0]        rd_cnt;
  logic [7:0]        drop_cnt;

  modport master (
    output en, wr, addr, din,
    input  dout, dout_valid, ready, wr_cnt, rd_cnt, drop_cnt
  );

  modport slave (
    input  en, wr, addr, din,
    output dout, dout_valid, ready, wr_cnt, rd_cnt, drop_cnt
  );
endinterface

// File: rtl/mem_stage_64x8.sv
// Single-port 2**ADDR_W x DATA_W memory that zero-fills itself after reset,
// then serves one read or write per cycle with registered read data.
module mem_stage_64x8 #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_stage_64x8_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              ready_q;
  logic              clr_we;
  logic              acc_wr;
  logic              acc_rd;
  logic              drop;
  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;
  logic [7:0]        wr_cnt_q, rd_cnt_q, drop_cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      INIT: begin
        clr_we = 1'b1;
        if (&clr_ptr_q) state_d = RUN;
      end
      RUN:  state_d = RUN;
    endcase
    // ready lags RUN by a cycle, so an accepted access never collides with the sweep
    if (bus.en) begin
      if (ready_q) begin
        acc_wr = bus.wr;
        acc_rd = !bus.wr;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      clr_ptr_q  <= '0;
      ready_q    <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_q == RUN);
      if (clr_we) clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
      if (acc_wr) wr_cnt_q <= sat_inc(wr_cnt_q);
      if (acc_rd) rd_cnt_q <= sat_inc(rd_cnt_q);
      if (drop)   drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  // Storage array has no reset; the INIT sweep is what makes it read as zero.
  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_ptr_q] <= '0;
    else if (acc_wr) mem[bus.addr]  <= bus.din;
  end

  // Stage p1: registered read data and its qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= acc_rd;
      if (acc_rd) dout_p1 <= mem[bus.addr];
    end
  end

  assign bus.dout       = dout_p1;
  assign bus.dout_valid = vld_p1;
  assign bus.ready      = ready_q;
  assign bus.wr_cnt     = wr_cnt_q;
  assign bus.rd_cnt     = rd_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_mem_stage_64x8.sv
// Bench for mem_stage_64x8: directed scenarios plus random traffic checked
// against an array-and-counter model of the memory stage.
module tb_mem_stage_64x8;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_stage_64x8_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_stage_64x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: edges since reset decide readiness; memory is all-zero after the sweep.
  logic [7:0] m_mem [64];
  int         m_edges;
  int         m_wr, m_rd, m_drop;
  logic [7:0] m_dout;
  logic       m_vld;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    m_edges = 0; m_wr = 0; m_rd = 0; m_drop = 0;
    m_dout = 8'h00; m_vld = 1'b0;
  endfunction

  function automatic bit model_ready();
    return m_edges >= 65;
  endfunction

  function automatic void model_apply(input logic en, input logic wr,
                                      input logic [5:0] a, input logic [7:0] d);
    bit rdy = model_ready();
    m_vld = 1'b0;
    if (en && rdy) begin
      if (wr) begin
        m_mem[a] = d;
        if (m_wr < 255) m_wr++;
      end else begin
        m_dout = m_mem[a];
        m_vld = 1'b1;
        if (m_rd < 255) m_rd++;
      end
    end else if (en) begin
      if (m_drop < 255) m_drop++;
    end
    m_edges++;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_apply(bus.en, bus.wr, bus.addr, bus.din);
    #1;
  endtask

  task automatic drive(input logic en, input logic wr, input logic [5:0] a, input logic [7:0] d);
    bus.en = en; bus.wr = wr; bus.addr = a; bus.din = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 200) begin
      cycle();
      n++;
      if (bus.ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 6'd0, 8'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", bus.dout); end
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", bus.dout_valid); end
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    n_tests++;
    if ({bus.wr_cnt, bus.rd_cnt, bus.drop_cnt} !== 24'h0) begin
      n_fail++; $display("FAIL reset_cnts got %h/%h/%h want 00/00/00", bus.wr_cnt, bus.rd_cnt, bus.drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ready_timing();
    int n;
    wait_ready(n);
    n_tests++; if (n != 65) begin n_fail++; $display("FAIL ready_latency got %0d want 65", n); end
    n_tests++;
    if ({bus.wr_cnt, bus.rd_cnt, bus.drop_cnt} !== 24'h0) begin
      n_fail++; $display("FAIL idle_cnts got %h/%h/%h want 00/00/00", bus.wr_cnt, bus.rd_cnt, bus.drop_cnt);
    end
  endtask

  task automatic test_write_read();
    logic [5:0] ra [5];
    logic [7:0] rexp [5];
    ra = '{6'd12, 6'd14, 6'd23, 6'd48, 6'd56};
    rexp = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00};
    drive(1'b1, 1'b1, 6'd12, 8'hA5); cycle();
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_vld got %b want 0", bus.dout_valid); end
    drive(1'b1, 1'b1, 6'd14, 8'h3C); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, ra[i], 8'hFF); cycle();
      n_tests++;
      if (bus.dout !== rexp[i] || bus.dout_valid !== 1'b1) begin
        n_fail++; $display("FAIL rd_%0d got %h/%b want %h/1", ra[i], bus.dout, bus.dout_valid, rexp[i]);
      end
    end
    drive(1'b0, 1'b0, 6'd12, 8'h00); cycle();
    n_tests++;
    if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_hold got %h/%b want 00/0", bus.dout, bus.dout_valid);
    end
    n_tests++;
    if (bus.wr_cnt !== 8'd2 || bus.rd_cnt !== 8'd5) begin
      n_fail++; $display("FAIL wr_rd_cnt got %0d/%0d want 2/5", bus.wr_cnt, bus.rd_cnt);
    end
  endtask

  task automatic test_raw();
    drive(1'b1, 1'b1, 6'd48, 8'h77); cycle();
    drive(1'b1, 1'b0, 6'd48, 8'h00); cycle();
    n_tests++;
    if (bus.dout !== 8'h77 || bus.dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL raw got %h/%b want 77/1", bus.dout, bus.dout_valid);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00); cycle();
  endtask

  task automatic test_drop_in_init();
    int n;
    int vld_seen = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 6'($urandom), 8'($urandom)); cycle();
      if (bus.dout_valid !== 1'b0) vld_seen++;
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    n_tests++; if (vld_seen != 0) begin n_fail++; $display("FAIL init_vld got %0d pulses want 0", vld_seen); end
    n_tests++;
    if (bus.drop_cnt !== 8'd10 || bus.rd_cnt !== 8'd0) begin
      n_fail++; $display("FAIL init_drop got drop=%0d rd=%0d want 10/0", bus.drop_cnt, bus.rd_cnt);
    end
    wait_ready(n);
    n_tests++; if (n != 55) begin n_fail++; $display("FAIL drop_ready got %0d want 55", n); end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [5:0] a;
      a = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      drive($urandom_range(0, 3) != 0, 1'($urandom), a, 8'($urandom));
      cycle();
      n_tests++;
      if (bus.dout_valid !== m_vld || (m_vld && bus.dout !== m_dout) || bus.dout !== m_dout) begin
        n_fail++; errs++;
        if (errs < 8) $display("FAIL rand_dout cyc %0d got %h/%b want %h/%b", i, bus.dout, bus.dout_valid, m_dout, m_vld);
      end
      n_tests++;
      if (bus.ready !== model_ready() || bus.wr_cnt !== 8'(m_wr) || bus.rd_cnt !== 8'(m_rd) ||
          bus.drop_cnt !== 8'(m_drop)) begin
        n_fail++; errs++;
        if (errs < 8) $display("FAIL rand_ctl cyc %0d got r=%b %0d/%0d/%0d want r=%b %0d/%0d/%0d", i, bus.ready,
                               bus.wr_cnt, bus.rd_cnt, bus.drop_cnt, model_ready(), m_wr, m_rd, m_drop);
      end
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 6'($urandom), 8'($urandom)); cycle();
      if (i % 60 == 59) begin
        n_tests++;
        if (bus.wr_cnt !== 8'(m_wr)) begin n_fail++; $display("FAIL sat_track got %0d want %0d", bus.wr_cnt, m_wr); end
      end
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00); cycle();
    n_tests++; if (bus.wr_cnt !== 8'd255) begin n_fail++; $display("FAIL wr_sat got %0d want 255", bus.wr_cnt); end
    drive(1'b1, 1'b1, 6'd1, 8'h01); cycle();
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    n_tests++; if (bus.wr_cnt !== 8'd255) begin n_fail++; $display("FAIL wr_sat_hold got %0d want 255", bus.wr_cnt); end
  endtask

  task automatic test_reset_mid_init();
    int n;
    drive(1'b1, 1'b1, 6'd23, 8'h11); cycle();
    drive(1'b1, 1'b0, 6'd23, 8'h00); cycle();
    n_tests++;
    if (bus.dout !== 8'h11) begin n_fail++; $display("FAIL pre_reset_rd got %h want 11", bus.dout); end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    do_reset();
    for (int i = 0; i < 30; i++) cycle();
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL mid_init_ready got %b want 0", bus.ready); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (bus.ready !== 1'b0 || bus.dout !== 8'h00) begin
      n_fail++; $display("FAIL async_rst got ready=%b dout=%h want 0/00", bus.ready, bus.dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    n_tests++; if (n != 65) begin n_fail++; $display("FAIL rerun_latency got %0d want 65", n); end
    n_tests++;
    if ({bus.wr_cnt, bus.rd_cnt, bus.drop_cnt} !== 24'h0) begin
      n_fail++; $display("FAIL rerun_cnts got %h/%h/%h want 00/00/00", bus.wr_cnt, bus.rd_cnt, bus.drop_cnt);
    end
    drive(1'b1, 1'b0, 6'd23, 8'h00); cycle();
    n_tests++;
    if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL cleared_rd got %h/%b want 00/1", bus.dout, bus.dout_valid);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ready_timing();
    test_write_read();
    test_raw();
    test_drop_in_init();
    test_random();
    test_saturation();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage_64x8.md
MEM_STAGE_64X8 -- requirements
Module: mem_stage_64x8

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, the address width, giving depth 2**ADDR_W = 64 words.
REQ-002 The block SHALL have parameter DATA_W, default 8, the data word width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit, the access request strobe, sampled each rising edge.
REQ-006 The block SHALL have port wr, input, 1 bit, the access type: 1 = write, 0 = read; it is ignored when en=0.
REQ-007 The block SHALL have port addr, input, ADDR_W bits, the word address of the access.
REQ-008 The block SHALL have port din, input, DATA_W bits, the write data.
REQ-009 The block SHALL have port dout, output, DATA_W bits, the registered read data.
REQ-010 The block SHALL have port dout_valid, output, 1 bit, a one-cycle pulse that qualifies dout.
REQ-011 The block SHALL have port ready, output, 1 bit; 1 = the clear sweep is done and requests are accepted.
REQ-012 The block SHALL have port wr_cnt, output, 8 bits, the count of accepted writes, saturating.
REQ-013 The block SHALL have port rd_cnt, output, 8 bits, the count of accepted reads, saturating.
REQ-014 The block SHALL have port drop_cnt, output, 8 bits, the count of requests with en=1 while ready=0, saturating.

Function
REQ-015 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT.
REQ-016 In INIT, the block SHALL write 0 to one word per cycle, at addresses 0, 1, ... 63 in order, taking 64 cycles.
REQ-017 After the cycle that clears address 63, the FSM SHALL move to RUN; ready SHALL be 1 from the next cycle onward.
REQ-018 RUN SHALL be terminal; the only way back to INIT SHALL be rst_n.
REQ-019 A request SHALL be accepted only when en=1 and ready=1 at the same rising edge.
REQ-020 An accepted write SHALL store din at mem[addr] at that edge; dout and dout_valid SHALL NOT change for a write.
REQ-021 An accepted read SHALL load mem[addr] into dout at that edge, so the data is visible in the next cycle, with dout_valid=1 for exactly that one cycle.
REQ-022 Back-to-back reads SHALL be supported: one read per cycle, with dout_valid held high continuously.
REQ-023 A read of an address written on the previous accepted edge SHALL return the newly written data.
REQ-024 Each edge SHALL perform at most one operation; there SHALL be no simultaneous read and write.
REQ-025 dout SHALL hold its last value when no read is accepted.
REQ-026 When en=1 and ready=0, the request SHALL have no effect on the memory or dout, and drop_cnt SHALL increment.
REQ-027 wr_cnt, rd_cnt and drop_cnt SHALL each stop at 255, with no wrap to 0.
REQ-028 Out-of-range addresses are impossible, since the full 2**ADDR_W space is implemented; no decoding error output SHALL exist.

Reset
REQ-029 While rst_n=0, the outputs SHALL be: dout=0, dout_valid=0, ready=0, wr_cnt=0, rd_cnt=0, drop_cnt=0; the FSM SHALL be in INIT and the clear pointer SHALL be 0.
REQ-030 rst_n assertion SHALL take effect immediately, without waiting for clk; deassertion SHALL be applied synchronously to clk by the integrator.
REQ-031 A reset asserted mid-INIT or mid-RUN SHALL abort the current operation; the clear sweep SHALL then restart from address 0, and ready SHALL stay 0 until the full sweep completes again.
REQ-032 Memory contents are not reset asynchronously; the INIT sweep alone SHALL guarantee that they read as zero.

Verification
REQ-033 Release reset and drive en=0 -> ready rises exactly 65 cycles after the first edge following deassertion; all counters stay at 0.
REQ-034 After ready=1: write addr 12 = 0xA5 and addr 14 = 0x3C (wr=1, en=1), then read addr 12, 14, 23, 48, 56 on consecutive cycles -> dout = 0xA5, 0x3C, 0x00, 0x00, 0x00 on the 5 cycles following each read; dout_valid is high for 5 consecutive cycles; wr_cnt=2, rd_cnt=5.
REQ-035 Write addr 48 = 0x77 on one edge and read addr 48 on the next edge -> dout=0x77 with dout_valid=1 on the following cycle.
REQ-036 Hold en=1, wr=0 during the first 10 INIT cycles -> drop_cnt=10, rd_cnt=0, and no dout_valid pulse.
REQ-037 Issue 300 accepted writes -> wr_cnt=255 and it stays at 255.
REQ-038 Write addr 23 = 0x11, pulse rst_n low at cycle 30 of a second INIT run, then wait for ready -> a read of addr 23 returns 0x00, and all counters are back to 0.
